cache_probe_sequencer: RTL and testbench

//  Hardware successor to the manual ACCESS/RESET bench flow for the cache lab.

---
 rtl/cache_probe_sequencer_if.sv | 48 ++++
 rtl/cache_probe_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cache_probe_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_probe_sequencer_if.sv
// Bundles the command, cacheSystem and result ports of cache_probe_sequencer.
// The master side is the host/bench and cache; the slave side is the sequencer.
interface cache_probe_sequencer_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned NUM_W  = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_stride;
    logic [NUM_W-1:0]  cmd_count;
    logic              cmd_flush;

    logic              cache_reset;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_enable;
    logic              cache_done;
    logic [DATA_W-1:0] cache_data;

    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_addr;
    logic [CNT_W-1:0]  res_delay;
    logic [DATA_W-1:0] res_data;
    logic              res_timeout;

    logic              busy;
    logic [CNT_W-1:0]  min_delay;
    logic [CNT_W-1:0]  max_delay;

    modport master (
        output cmd_valid, cmd_base, cmd_stride, cmd_count, cmd_flush,
        output cache_done, cache_data, res_ready,
        input  cmd_ready, cache_reset, cache_addr, cache_enable,
        input  res_valid, res_addr, res_delay, res_data, res_timeout,
        input  busy, min_delay, max_delay
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_stride, cmd_count, cmd_flush,
        input  cache_done, cache_data, res_ready,
        output cmd_ready, cache_reset, cache_addr, cache_enable,
        output res_valid, res_addr, res_delay, res_data, res_timeout,
        output busy, min_delay, max_delay
    );
endinterface

// File: rtl/cache_probe_sequencer.sv
// Sweeps cacheSystem with base/stride/count accesses, timing each one in cycles and
// streaming per-access results with running min/max latency.
module cache_probe_sequencer #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned NUM_W   = 12,
    parameter int unsigned TIMEOUT = 10000
) (
    input logic                    clk_i,
    input logic                    rst_i,
    cache_probe_sequencer_if.slave bus_io
);
    typedef enum logic [2:0] {
        StIdle, StFlushHi, StFlushLo, StIssue, StWait, StRelease, StReport
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d, cache_addr_q, cache_addr_d;
    logic [NUM_W-1:0]  left_q, left_d;
    logic [CNT_W-1:0]  delay_q, delay_d, min_q, min_d, max_q, max_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [CNT_W-1:0]  res_delay_q, res_delay_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_timeout_q, res_timeout_d;
    logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d, res_valid_q, res_valid_d;
    logic              cache_reset_q, cache_reset_d, cache_enable_q, cache_enable_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        left_d        = left_q;
        delay_d       = delay_q;
        min_d         = min_q;
        max_d         = max_q;
        res_addr_d    = res_addr_q;
        res_delay_d   = res_delay_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.cmd_valid) begin
                    min_d    = '1;
                    max_d    = '0;
                    addr_d   = bus_io.cmd_base;
                    stride_d = bus_io.cmd_stride;
                    left_d   = bus_io.cmd_count;
                    if (bus_io.cmd_count != '0) begin
                        state_d = bus_io.cmd_flush ? StFlushHi : StIssue;
                    end
                end
            end
            StFlushHi: state_d = StFlushLo;
            StFlushLo: state_d = StIssue;
            StIssue: begin
                delay_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus_io.cache_done) begin
                    res_addr_d    = addr_q;
                    res_delay_d   = delay_q;
                    res_data_d    = bus_io.cache_data;
                    res_timeout_d = 1'b0;
                    state_d       = StRelease;
                end else if (delay_q == CNT_W'(TIMEOUT - 1)) begin
                    res_addr_d    = addr_q;
                    res_delay_d   = CNT_W'(TIMEOUT);
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = StRelease;
                end else begin
                    delay_d = delay_q + CNT_W'(1);
                end
            end
            StRelease: begin
                // Stats fold in as the result becomes visible; timeouts are excluded.
                if (!res_timeout_q) begin
                    if (res_delay_q < min_q) min_d = res_delay_q;
                    if (res_delay_q > max_q) max_d = res_delay_q;
                end
                state_d = StReport;
            end
            StReport: begin
                if (bus_io.res_ready) begin
                    if (left_q == NUM_W'(1)) begin
                        state_d = StIdle;
                    end else begin
                        left_d  = left_q - NUM_W'(1);
                        addr_d  = addr_q + stride_q;
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of what the next state implies.
        cmd_ready_d    = (state_d == StIdle);
        busy_d         = (state_d != StIdle);
        cache_reset_d  = (state_d == StFlushHi);
        cache_enable_d = (state_d == StIssue) || (state_d == StWait);
        res_valid_d    = (state_d == StReport);
        cache_addr_d   = (state_d == StIssue) ? addr_d : cache_addr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            stride_q       <= '0;
            left_q         <= '0;
            delay_q        <= '0;
            min_q          <= '1;
            max_q          <= '0;
            res_addr_q     <= '0;
            res_delay_q    <= '0;
            res_data_q     <= '0;
            res_timeout_q  <= 1'b0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            cache_reset_q  <= 1'b0;
            cache_enable_q <= 1'b0;
            cache_addr_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            stride_q       <= stride_d;
            left_q         <= left_d;
            delay_q        <= delay_d;
            min_q          <= min_d;
            max_q          <= max_d;
            res_addr_q     <= res_addr_d;
            res_delay_q    <= res_delay_d;
            res_data_q     <= res_data_d;
            res_timeout_q  <= res_timeout_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            res_valid_q    <= res_valid_d;
            cache_reset_q  <= cache_reset_d;
            cache_enable_q <= cache_enable_d;
            cache_addr_q   <= cache_addr_d;
        end
    end

    assign bus_io.cmd_ready    = cmd_ready_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.cache_reset  = cache_reset_q;
    assign bus_io.cache_enable = cache_enable_q;
    assign bus_io.cache_addr   = cache_addr_q;
    assign bus_io.res_valid    = res_valid_q;
    assign bus_io.res_addr     = res_addr_q;
    assign bus_io.res_delay    = res_delay_q;
    assign bus_io.res_data     = res_data_q;
    assign bus_io.res_timeout  = res_timeout_q;
    assign bus_io.min_delay    = min_q;
    assign bus_io.max_delay    = max_q;
endmodule

// File: tb/tb_cache_probe_sequencer.sv
// Directed bench for cache_probe_sequencer driving a behavioural cache with
// programmable hit/miss latency (latency here = the delay the sequencer must report).
module tb_cache_probe_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hit_lat  = 3;
    int   miss_lat = 3;
    int   rst_hi_cnt = 0;
    int   mcnt = 0;
    int   cur_lat = 0;
    bit   present[int];

    always #5 clk = ~clk;

    cache_probe_sequencer_if bus ();

    cache_probe_sequencer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus.slave)
    );

    function automatic logic [31:0] data_of(input logic [14:0] a);
        return {a, 17'h1ABCD};
    endfunction

    // Cache model: done rises so that the sequencer's first WAIT edge sees it after lat edges.
    always @(posedge clk or posedge rst) begin
        #1;
        if (bus.cache_reset) present.delete();
        if (bus.cache_enable) begin
            if (mcnt == 0) begin
                cur_lat = present.exists(int'(bus.cache_addr)) ? hit_lat : miss_lat;
                present[int'(bus.cache_addr)] = 1'b1;
            end
            mcnt++;
            bus.cache_done = (mcnt >= cur_lat + 2);
            bus.cache_data = data_of(bus.cache_addr);
        end else begin
            mcnt = 0;
            bus.cache_done = 1'b0;
            bus.cache_data = 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) if (bus.cache_reset) rst_hi_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [14:0] base, input logic [14:0] stride,
                            input logic [11:0] count, input logic flush);
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_base   = base;
        bus.cmd_stride = stride;
        bus.cmd_count  = count;
        bus.cmd_flush  = flush;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %0b exp 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", bus.busy); else n_pass++;
        n_checks++; if ({bus.cache_enable, bus.cache_reset, bus.res_valid, bus.res_timeout} !== 4'b0)
            $display("FAIL rst_ctrl got %b exp 0000", {bus.cache_enable, bus.cache_reset, bus.res_valid, bus.res_timeout}); else n_pass++;
        n_checks++; if ({bus.cache_addr, bus.res_addr, bus.res_delay} !== 46'h0)
            $display("FAIL rst_addr_delay got %0h exp 0", {bus.cache_addr, bus.res_addr, bus.res_delay}); else n_pass++;
        n_checks++; if (bus.res_data !== 32'h0) $display("FAIL rst_res_data got %0h exp 0", bus.res_data); else n_pass++;
        n_checks++; if (bus.min_delay !== 16'hFFFF || bus.max_delay !== 16'h0)
            $display("FAIL rst_minmax got %0h/%0h exp ffff/0", bus.min_delay, bus.max_delay); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fixed_latency();
        bit got;
        hit_lat = 3; miss_lat = 3;
        send_cmd(15'h0, 15'h0, 12'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_res(200, got);
            n_checks++; if (!got) $display("FAIL fix_valid%0d got 0 exp 1", k); else n_pass++;
            n_checks++; if (bus.res_delay !== 16'd3) $display("FAIL fix_delay%0d got %0d exp 3", k, bus.res_delay); else n_pass++;
            n_checks++; if (bus.res_data !== data_of(15'h0) || bus.res_addr !== 15'h0 || bus.res_timeout !== 1'b0)
                $display("FAIL fix_res%0d got %0h/%0h/%0b exp %0h/0/0", k, bus.res_data, bus.res_addr, bus.res_timeout, data_of(15'h0)); else n_pass++;
            consume();
        end
        n_checks++; if (bus.min_delay !== 16'd3 || bus.max_delay !== 16'd3)
            $display("FAIL fix_minmax got %0d/%0d exp 3/3", bus.min_delay, bus.max_delay); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || rst_hi_cnt !== 0)
            $display("FAIL fix_idle got busy=%0b resets=%0d exp 0/0", bus.busy, rst_hi_cnt); else n_pass++;
    endtask

    task automatic test_flush_hit_miss();
        bit got;
        hit_lat = 2; miss_lat = 40; rst_hi_cnt = 0;
        send_cmd(15'h0, 15'h0, 12'd2, 1'b1);
        wait_res(200, got);
        n_checks++; if (!got || bus.res_delay !== 16'd40) $display("FAIL flush_miss got %0b/%0d exp 1/40", got, bus.res_delay); else n_pass++;
        consume();
        wait_res(200, got);
        n_checks++; if (!got || bus.res_delay !== 16'd2) $display("FAIL flush_hit got %0b/%0d exp 1/2", got, bus.res_delay); else n_pass++;
        n_checks++; if (bus.min_delay !== 16'd2 || bus.max_delay !== 16'd40)
            $display("FAIL flush_minmax got %0d/%0d exp 2/40", bus.min_delay, bus.max_delay); else n_pass++;
        consume();
        n_checks++; if (rst_hi_cnt !== 1) $display("FAIL flush_pulse got %0d cycles exp 1", rst_hi_cnt); else n_pass++;
    endtask

    task automatic test_count_zero();
        bit seen = 1'b0;
        send_cmd(15'h33, 15'h1, 12'd0, 1'b0);
        n_checks++; if (bus.min_delay !== 16'hFFFF || bus.max_delay !== 16'h0)
            $display("FAIL zero_minmax got %0h/%0h exp ffff/0", bus.min_delay, bus.max_delay); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (bus.res_valid || bus.busy || bus.cache_enable) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL zero_idle got activity=1 exp 0"); else n_pass++;
    endtask

    task automatic test_wrap();
        bit got;
        logic [14:0] exp_addr [3];
        exp_addr[0] = 15'h7FF0; exp_addr[1] = 15'h0000; exp_addr[2] = 15'h0010;
        hit_lat = 1; miss_lat = 1;
        send_cmd(15'h7FF0, 15'h10, 12'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_res(200, got);
            n_checks++; if (!got || bus.res_addr !== exp_addr[k] || bus.res_data !== data_of(exp_addr[k]))
                $display("FAIL wrap_addr%0d got %0h/%0h exp %0h/%0h", k, bus.res_addr, bus.res_data, exp_addr[k], data_of(exp_addr[k])); else n_pass++;
            consume();
        end
    endtask

    task automatic test_timeout();
        bit got;
        hit_lat = 1_000_000; miss_lat = 1_000_000;
        send_cmd(15'h123, 15'h0, 12'd1, 1'b0);
        wait_res(10100, got);
        n_checks++; if (!got || bus.res_timeout !== 1'b1) $display("FAIL to_flag got %0b/%0b exp 1/1", got, bus.res_timeout); else n_pass++;
        n_checks++; if (bus.res_delay !== 16'd10000 || bus.res_data !== 32'h0)
            $display("FAIL to_delay_data got %0d/%0h exp 10000/0", bus.res_delay, bus.res_data); else n_pass++;
        n_checks++; if (bus.min_delay !== 16'hFFFF || bus.max_delay !== 16'h0)
            $display("FAIL to_minmax got %0h/%0h exp ffff/0", bus.min_delay, bus.max_delay); else n_pass++;
        consume();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL to_idle got %0b exp 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got;
        bit stable = 1'b1;
        logic [14:0] s_addr;
        logic [15:0] s_delay;
        logic [31:0] s_data;
        hit_lat = 5; miss_lat = 5;
        send_cmd(15'h100, 15'h4, 12'd2, 1'b0);
        wait_res(200, got);
        s_addr = bus.res_addr; s_delay = bus.res_delay; s_data = bus.res_data;
        n_checks++; if (!got || s_addr !== 15'h100 || s_delay !== 16'd5)
            $display("FAIL bp_first got %0b/%0h/%0d exp 1/100/5", got, s_addr, s_delay); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            bus.cmd_valid = (i == 3);
            bus.cmd_base  = 15'h555;
            bus.cmd_count = 12'd1;
            @(negedge clk);
            if (!bus.res_valid || bus.cache_enable || bus.res_addr !== s_addr ||
                bus.res_delay !== s_delay || bus.res_data !== s_data) stable = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_stable got 0 exp 1"); else n_pass++;
        consume();
        n_checks++; if (bus.cache_enable !== 1'b1 || bus.cache_addr !== 15'h104)
            $display("FAIL bp_next_issue got %0b/%0h exp 1/104", bus.cache_enable, bus.cache_addr); else n_pass++;
        wait_res(200, got);
        n_checks++; if (!got || bus.res_addr !== 15'h104 || bus.res_delay !== 16'd5)
            $display("FAIL bp_second got %0b/%0h/%0d exp 1/104/5", got, bus.res_addr, bus.res_delay); else n_pass++;
        consume();
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0)
            $display("FAIL bp_no_queue got %0b/%0b exp 0/0", bus.busy, bus.res_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        hit_lat = 1_000_000; miss_lat = 1_000_000;
        send_cmd(15'h40, 15'h0, 12'd1, 1'b0);
        repeat (5) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1 || bus.cache_enable !== 1'b1)
            $display("FAIL mid_pre got %0b/%0b exp 1/1", bus.busy, bus.cache_enable); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({bus.cache_enable, bus.busy, bus.res_valid, bus.cmd_ready} !== 4'b0001)
            $display("FAIL mid_async got %b exp 0001", {bus.cache_enable, bus.busy, bus.res_valid, bus.cmd_ready}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        hit_lat = 3; miss_lat = 3;
        send_cmd(15'h55, 15'h0, 12'd1, 1'b0);
        wait_res(200, got);
        n_checks++; if (!got || bus.res_addr !== 15'h55 || bus.res_delay !== 16'd3)
            $display("FAIL mid_rerun got %0b/%0h/%0d exp 1/55/3", got, bus.res_addr, bus.res_delay); else n_pass++;
        consume();
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_stride = '0;
        bus.cmd_count  = '0;
        bus.cmd_flush  = 1'b0;
        bus.res_ready  = 1'b0;
        test_reset();
        test_fixed_latency();
        test_flush_hit_miss();
        test_count_zero();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
